// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// blank pattern and segment bit positions in the {g,f,e,d,c,b,a} bus.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Entry n is the lit-segment pattern for hex digit n (entry 15 first).
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_TABLE[nib];

endmodule

// File: rtl/seg_scan_dev.sv
// Time-multiplexed hex seven-segment driver with per-digit write registers.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_dev
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    localparam int ADR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADR_W-1:0]  adr,
    input  logic [3:0]        data,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              frame
);

    localparam int PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [3:0]        value [DIGITS];
    logic [DIGITS-1:0] valid;
    logic [PCNT_W-1:0] pcnt;
    logic [ADR_W-1:0]  idx;

    logic [3:0] cur_val;
    logic [6:0] dec_seg;
    logic [6:0] seg_next;
    logic       lz_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) value[i] <= 4'h0;
            valid <= '0;
        end else if (we && (32'(adr) < DIGITS)) begin
            value[adr] <= data;
            valid[adr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (pcnt == PCNT_W'(DIV - 1)) begin
            pcnt <= '0;
            idx  <= (idx == ADR_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign cur_val = value[idx];

    seg_hex_dec u_dec (
        .nib (cur_val),
        .seg (dec_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    logic upper_zero;

    // A zero digit goes dark only when nothing significant sits above it.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if ((j > int'(idx)) && valid[j] && (value[j] != 4'h0)) upper_zero = 1'b0;
        end
        lz_blank = upper_zero && (cur_val == 4'h0) && (idx != '0);
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign seg_next = (valid[idx] && !lz_blank) ? dec_seg : SEG_BLANK;

    // Outputs lag the scan counters by one cycle; pcnt == 0 is the blank slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg   <= SEG_BLANK;
            an    <= '0;
            frame <= 1'b0;
        end else begin
            frame <= (pcnt == '0) && (idx == '0);
            if (pcnt == '0) begin
                seg <= SEG_BLANK;
                an  <= '0;
            end else begin
                seg <= seg_next;
                an  <= {{(DIGITS-1){1'b0}}, 1'b1} << idx;
            end
        end
    end

endmodule
